// File: rtl/button_pulse_conditioner_pkg.sv
// Shared constants and types for the stopwatch button front end.
package stopwatch_pkg;

    localparam int unsigned BTN_STARTSTOP = 0;
    localparam int unsigned BTN_RESET     = 1;
    localparam int unsigned BTN_INC       = 2;

    // Cycle counts at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_100MHZ = 1_000_000;
    localparam int unsigned REPEAT_DELAY_100MHZ    = 50_000_000;
    localparam int unsigned REPEAT_PERIOD_100MHZ   = 10_000_000;

    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_REPEAT_DELAY    = 20;
    localparam int unsigned SIM_REPEAT_PERIOD   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } btn_state_t;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/button_pulse_conditioner_debounce_channel.sv
// One button: 2-flop synchronizer, debounce counter, press/repeat FSM.
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam int unsigned DW   = clog2_min1(DEBOUNCE_CYCLES);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = clog2_min1(RMAX);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync_meta;
    logic          sync;
    logic [DW-1:0] db_count;
    logic [DW-1:0] db_count_next;
    logic          level_next;
    logic          accept;
    logic [RW-1:0] rep_count;
    logic [RW-1:0] rep_count_next;
    logic          pulse_next;
    btn_state_t    state;
    btn_state_t    state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            db_count  <= '0;
            level     <= 1'b0;
            rep_count <= '0;
            pulse     <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
            db_count  <= db_count_next;
            level     <= level_next;
            rep_count <= rep_count_next;
            pulse     <= pulse_next;
            state     <= state_next;
        end
    end

    always_comb begin
        db_count_next  = '0;
        level_next     = level;
        accept         = 1'b0;
        state_next     = state;
        rep_count_next = '0;
        pulse_next     = 1'b0;

        if (sync != level) begin
            if (db_count == DB_LAST) begin
                accept     = 1'b1;
                level_next = sync;
            end else begin
                db_count_next = db_count + 1'b1;
            end
        end

        // Repeat slots still reload while a release is being debounced,
        // but the pulse itself is gated by the synchronized level.
        unique case (state)
            ST_IDLE: begin
                if (accept && sync) begin
                    state_next = ST_HELD;
                    pulse_next = 1'b1;
                end
            end
            ST_HELD: begin
                if (accept && !sync) begin
                    state_next = ST_IDLE;
                end else if (REPEAT_EN) begin
                    if (rep_count == DELAY_LAST) begin
                        state_next = ST_REPEAT;
                        pulse_next = sync;
                    end else begin
                        rep_count_next = rep_count + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (accept && !sync) begin
                    state_next = ST_IDLE;
                end else if (rep_count == PERIOD_LAST) begin
                    pulse_next = sync;
                end else begin
                    rep_count_next = rep_count + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Button front end: one independent debounce/pulse channel per button.
module button_pulse_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned          NUM_BTN         = 3,
    parameter int unsigned          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int unsigned          REPEAT_DELAY    = REPEAT_DELAY_100MHZ,
    parameter int unsigned          REPEAT_PERIOD   = REPEAT_PERIOD_100MHZ,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK     = NUM_BTN'(1 << BTN_INC)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (btn_raw[i]),
            .level   (level[i]),
            .pulse   (pulse[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor checks them.
module tb_button_pulse_conditioner;
    import stopwatch_pkg::*;

    // raw edge k -> pulse after edge k+5; driving just after edge c puts k at c+1
    localparam int LAT    = 6;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] level;
    logic [2:0] pulse;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        logic [2:0] val;
    } exp_t;
    exp_t exp_q[$];

    button_pulse_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (SIM_REPEAT_DELAY),
        .REPEAT_PERIOD   (SIM_REPEAT_PERIOD),
        .REPEAT_MASK     (3'b100)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_raw),
        .level   (level),
        .pulse   (pulse)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: got none at cycle %0d, required %b", exp_q[0].at, exp_q[0].val);
            void'(exp_q.pop_front());
        end
        if (pulse != 3'b000) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].at != cyc) begin
                errors++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required 000", pulse, cyc);
            end else begin
                if (pulse !== exp_q[0].val) begin
                    errors++;
                    $display("FAIL pulse_value: got %b at cycle %0d, required %b", pulse, cyc, exp_q[0].val);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_pulse(input int at, input logic [2:0] val);
        exp_t e;
        e.at  = at;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    initial begin
        int c;

        tick(3);
        reset = 1'b0;
        check("reset_level", int'(level), 0);
        check("reset_pulse", int'(pulse), 0);

        // clean press on channel 0, held 40 cycles
        tick(1);
        c = cyc;
        btn_raw[0] = 1'b1;
        expect_pulse(c + LAT, 3'b001);
        tick(LAT - 1);
        check("clean_level_before", int'(level), 0);
        tick(1);
        check("clean_level_rise", int'(level), 1);
        tick(40 - LAT);
        btn_raw[0] = 1'b0;
        tick(LAT - 1);
        check("clean_level_hold", int'(level), 1);
        tick(1);
        check("clean_level_fall", int'(level), 0);
        tick(5);

        // bounce on channel 2: 3 high, 1 low, 2 high, low
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[2] = 1'b0;
        tick(1);
        btn_raw[2] = 1'b1;
        tick(2);
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("bounce_level", int'(level), 0);
        end
        c = cyc;
        btn_raw[2] = 1'b1;
        expect_pulse(c + LAT, 3'b100);
        tick(10);
        check("bounce_final_level", int'(level), 4);
        btn_raw[2] = 1'b0;
        tick(12);
        check("bounce_release_level", int'(level), 0);

        // auto-repeat on channel 2, 60-cycle hold
        c = cyc;
        btn_raw[2] = 1'b1;
        expect_pulse(c + LAT, 3'b100);
        for (int n = 0; n < 5; n++)
            expect_pulse(c + LAT + DELAY + n * PERIOD, 3'b100);
        tick(60);
        check("repeat_level_held", int'(level), 4);
        btn_raw[2] = 1'b0;
        tick(12);
        check("repeat_level_released", int'(level), 0);

        // same hold on channel 0: no repeat
        c = cyc;
        btn_raw[0] = 1'b1;
        expect_pulse(c + LAT, 3'b001);
        tick(60);
        btn_raw[0] = 1'b0;
        tick(12);
        check("norepeat_level_released", int'(level), 0);

        // release sampled two edges before the second repeat slot
        c = cyc;
        btn_raw[2] = 1'b1;
        expect_pulse(c + LAT, 3'b100);
        expect_pulse(c + LAT + DELAY, 3'b100);
        tick(31);
        btn_raw[2] = 1'b0;
        tick(5);
        check("release_level_debouncing", int'(level), 4);
        tick(1);
        check("release_level_fall", int'(level), 0);
        tick(30);

        // reset while channel 2 is repeating, button still held
        c = cyc;
        btn_raw[2] = 1'b1;
        expect_pulse(c + LAT, 3'b100);
        expect_pulse(c + LAT + DELAY, 3'b100);
        tick(30);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_level", int'(level), 0);
        check("midreset_pulse", int'(pulse), 0);
        expect_pulse(cyc + LAT, 3'b100);
        expect_pulse(cyc + LAT + DELAY, 3'b100);
        expect_pulse(cyc + LAT + DELAY + PERIOD, 3'b100);
        tick(35);
        btn_raw[2] = 1'b0;
        tick(12);
        check("midreset_level_released", int'(level), 0);

        // simultaneous press on channels 0 and 1
        c = cyc;
        btn_raw = 3'b011;
        expect_pulse(c + LAT, 3'b011);
        tick(10);
        check("simul_level", int'(level), 3);
        btn_raw = 3'b000;
        tick(12);
        check("simul_level_released", int'(level), 0);

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
